av_master_port: RTL and testbench

Register-mapped Avalon-MM master that lets the MCU drive the Qsys `m0` port. It sits between the MCU register file and the Qsys interconnect. MCU register loads and reads trigger single-word write and read transactions. `mcu_wait` stalls the MCU until each transaction completes. The block adds optional address auto-increment and a waitrequest timeout with a sticky error flag.

---
 rtl/av_master_port.sv | 134 +++++++++++++
 tb/tb_av_master_port.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/av_master_port.sv
// av_master_port: register-mapped Avalon-MM master.
// MCU register loads and reads launch single-word Avalon transactions.
// mcu_wait holds the MCU off until each transaction has finished.
// Optional address auto-increment is supported.
// A waitrequest timeout aborts a stuck transaction and sets a sticky flag.
module av_master_port #(
  parameter int unsigned INC_STEP       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] r_load_data,
  input  logic        ld_ad_hi,
  input  logic        ld_ad_lo,
  input  logic        ld_write_data,
  input  logic        ld_ctrl,
  input  logic        rd_write_data,
  output logic [15:0] ad_hi,
  output logic [15:0] ad_lo,
  output logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic [15:0] status,
  output logic        mcu_wait,
  output logic [31:0] av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        av_waitrequest
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [31:0] INC_VAL       = 32'(INC_STEP);
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] adHi_q, adHi_d;
  logic [15:0] adLo_q, adLo_d;
  logic [15:0] writeData_q, writeData_d;
  logic [15:0] readData_q, readData_d;
  logic        autoInc_q, autoInc_d;
  logic        timeout_q, timeout_d;
  logic [31:0] waitCnt_q, waitCnt_d;
  logic        mcuWait_q;
  logic        timeoutSet;

  // Next-state logic: command decode, waitrequest handling, timeout and auto-increment
  always_comb begin
    state_d     = state_q;
    adHi_d      = adHi_q;
    adLo_d      = adLo_q;
    writeData_d = writeData_q;
    readData_d  = readData_q;
    autoInc_d   = autoInc_q;
    timeout_d   = timeout_q;
    waitCnt_d   = waitCnt_q;
    timeoutSet  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_ad_hi) adHi_d = r_load_data;
        if (ld_ad_lo) adLo_d = r_load_data;
        if (ld_ctrl)  autoInc_d = r_load_data[0];
        // A write strobe takes priority; a simultaneous read strobe is dropped
        if (ld_write_data) begin
          writeData_d = r_load_data;
          state_d     = WRITE;
          waitCnt_d   = '0;
        end else if (rd_write_data) begin
          state_d   = READ;
          waitCnt_d = '0;
        end
      end
      WRITE, READ: begin
        if (!av_waitrequest) begin
          state_d = DONE;
          if (state_q == READ) readData_d = av_readdata;
          if (autoInc_q) {adHi_d, adLo_d} = {adHi_q, adLo_q} + INC_VAL;
        end else begin
          waitCnt_d = waitCnt_q + 32'd1;
          // Abort on the TIMEOUT_CYCLES-th stalled edge; no capture, no increment
          if ((TIMEOUT_LIMIT != 32'd0) && (waitCnt_q == TIMEOUT_LIMIT - 32'd1)) begin
            state_d    = DONE;
            timeoutSet = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The flag clear is honoured in any state, but a same-edge set wins
    if (ld_ctrl && r_load_data[1]) timeout_d = 1'b0;
    if (timeoutSet) timeout_d = 1'b1;
  end

  // State and register file; mcu_wait is registered from the next state
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q     <= IDLE;
      adHi_q      <= '0;
      adLo_q      <= '0;
      writeData_q <= '0;
      readData_q  <= '0;
      autoInc_q   <= 1'b0;
      timeout_q   <= 1'b0;
      waitCnt_q   <= '0;
      mcuWait_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      adHi_q      <= adHi_d;
      adLo_q      <= adLo_d;
      writeData_q <= writeData_d;
      readData_q  <= readData_d;
      autoInc_q   <= autoInc_d;
      timeout_q   <= timeout_d;
      waitCnt_q   <= waitCnt_d;
      mcuWait_q   <= (state_d != IDLE);
    end
  end

  assign ad_hi        = adHi_q;
  assign ad_lo        = adLo_q;
  assign write_data   = writeData_q;
  assign read_data    = readData_q;
  assign status       = {13'd0, autoInc_q, timeout_q, mcuWait_q};
  assign mcu_wait     = mcuWait_q;
  assign av_address   = {adHi_q, adLo_q};
  assign av_writedata = writeData_q;
  assign av_write     = (state_q == WRITE);
  assign av_read      = (state_q == READ);

endmodule

// File: tb/tb_av_master_port.sv
// Testbench for av_master_port.
// A table of per-cycle vectors covers write, read, auto-increment and simultaneous triggers.
// Hand sequences cover timeout abort and reset mid-transaction.
module tb_av_master_port;

  logic        sysclk;
  logic        sysreset;
  logic [15:0] r_load_data;
  logic        ld_ad_hi, ld_ad_lo, ld_write_data, ld_ctrl, rd_write_data;
  logic [15:0] ad_hi, ad_lo, write_data, read_data, status;
  logic        mcu_wait;
  logic [31:0] av_address;
  logic        av_read, av_write;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;

  int checkCount = 0;
  int passCount  = 0;

  av_master_port #(.INC_STEP(2), .TIMEOUT_CYCLES(8)) dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .r_load_data   (r_load_data),
    .ld_ad_hi      (ld_ad_hi),
    .ld_ad_lo      (ld_ad_lo),
    .ld_write_data (ld_write_data),
    .ld_ctrl       (ld_ctrl),
    .rd_write_data (rd_write_data),
    .ad_hi         (ad_hi),
    .ad_lo         (ad_lo),
    .write_data    (write_data),
    .read_data     (read_data),
    .status        (status),
    .mcu_wait      (mcu_wait),
    .av_address    (av_address),
    .av_read       (av_read),
    .av_write      (av_write),
    .av_writedata  (av_writedata),
    .av_readdata   (av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  // 10 ns system clock
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  typedef struct {
    logic        ldHi, ldLo, ldWd, rdWd, ldCtrl;
    logic [15:0] data;
    logic        waitReq;
    logic [15:0] rdata;
    logic        expWrite, expRead, expWait;
    logic [31:0] expAddr;
    logic [15:0] expWdata, expRdata, expStatus;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic setInputs(input logic hi, input logic lo, input logic wd, input logic rd,
                           input logic ctl, input logic [15:0] data, input logic wr,
                           input logic [15:0] rdata);
    ld_ad_hi       = hi;
    ld_ad_lo       = lo;
    ld_write_data  = wd;
    rd_write_data  = rd;
    ld_ctrl        = ctl;
    r_load_data    = data;
    av_waitrequest = wr;
    av_readdata    = rdata;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.ldHi, v.ldLo, v.ldWd, v.rdWd, v.ldCtrl, v.data, v.waitReq, v.rdata);
    tick();
  endtask

  initial begin
    // ldHi ldLo ldWd rdWd ldCtrl data wr rdata | W R Wait addr wdata rdata status
    vecs[0]  = '{1,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,32'h00000000,16'h0000,16'h0000,16'h0000};
    vecs[1]  = '{0,1,0,0,0,16'h0100,0,16'h0000, 0,0,0,32'h00000100,16'h0000,16'h0000,16'h0000};
    vecs[2]  = '{0,0,1,0,0,16'hBEEF,0,16'h0000, 1,0,1,32'h00000100,16'hBEEF,16'h0000,16'h0001};
    vecs[3]  = '{0,0,0,0,0,16'h0000,0,16'h0000, 0,0,1,32'h00000100,16'hBEEF,16'h0000,16'h0001};
    vecs[4]  = '{0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,32'h00000100,16'hBEEF,16'h0000,16'h0000};
    vecs[5]  = '{0,0,0,1,0,16'h0000,1,16'hDEAD, 0,1,1,32'h00000100,16'hBEEF,16'h0000,16'h0001};
    vecs[6]  = '{0,0,0,0,0,16'h0000,1,16'hDEAD, 0,1,1,32'h00000100,16'hBEEF,16'h0000,16'h0001};
    vecs[7]  = '{0,0,0,0,0,16'h0000,1,16'hDEAD, 0,1,1,32'h00000100,16'hBEEF,16'h0000,16'h0001};
    vecs[8]  = '{0,0,0,0,0,16'h0000,1,16'hDEAD, 0,1,1,32'h00000100,16'hBEEF,16'h0000,16'h0001};
    vecs[9]  = '{0,0,0,0,0,16'h0000,0,16'h1234, 0,0,1,32'h00000100,16'hBEEF,16'h1234,16'h0001};
    vecs[10] = '{0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,32'h00000100,16'hBEEF,16'h1234,16'h0000};
    vecs[11] = '{0,0,0,0,1,16'h0001,0,16'h0000, 0,0,0,32'h00000100,16'hBEEF,16'h1234,16'h0004};
    vecs[12] = '{1,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,32'h00000100,16'hBEEF,16'h1234,16'h0004};
    vecs[13] = '{0,1,0,0,0,16'hFFFE,0,16'h0000, 0,0,0,32'h0000FFFE,16'hBEEF,16'h1234,16'h0004};
    vecs[14] = '{0,0,1,0,0,16'h0042,0,16'h0000, 1,0,1,32'h0000FFFE,16'h0042,16'h1234,16'h0005};
    vecs[15] = '{0,1,0,0,0,16'hAAAA,0,16'h0000, 0,0,1,32'h00010000,16'h0042,16'h1234,16'h0005};
    vecs[16] = '{0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,32'h00010000,16'h0042,16'h1234,16'h0004};
    vecs[17] = '{0,0,1,1,0,16'h0777,0,16'h9999, 1,0,1,32'h00010000,16'h0777,16'h1234,16'h0005};
    vecs[18] = '{0,0,0,0,0,16'h0000,0,16'h9999, 0,0,1,32'h00010002,16'h0777,16'h1234,16'h0005};
    vecs[19] = '{0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,32'h00010002,16'h0777,16'h1234,16'h0004};
    vecs[20] = '{0,0,0,0,1,16'h0000,0,16'h0000, 0,0,0,32'h00010002,16'h0777,16'h1234,16'h0000};

    sysreset = 1'b1;
    setInputs(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    tick();
    tick();
    checkOutput("reset_av_write", 32'(av_write), 32'd0);
    checkOutput("reset_av_read", 32'(av_read), 32'd0);
    checkOutput("reset_mcu_wait", 32'(mcu_wait), 32'd0);
    checkOutput("reset_status", 32'(status), 32'd0);
    checkOutput("reset_address", av_address, 32'd0);
    @(negedge sysclk);
    sysreset = 1'b0;
    tick();

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_av_write", i), 32'(av_write), 32'(vecs[i].expWrite));
      checkOutput($sformatf("vec%0d_av_read", i), 32'(av_read), 32'(vecs[i].expRead));
      checkOutput($sformatf("vec%0d_mcu_wait", i), 32'(mcu_wait), 32'(vecs[i].expWait));
      checkOutput($sformatf("vec%0d_av_address", i), av_address, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_av_writedata", i), 32'(av_writedata), 32'(vecs[i].expWdata));
      checkOutput($sformatf("vec%0d_read_data", i), 32'(read_data), 32'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].expStatus));
    end

    // Prime read_data with 0x5555 using a zero-wait read
    setInputs(0, 0, 0, 1, 0, 16'h0000, 0, 16'h5555);
    tick();
    setInputs(0, 0, 0, 0, 0, 16'h0000, 0, 16'h5555);
    tick();
    checkOutput("prime_read_data", 32'(read_data), 32'h5555);
    tick();

    // Timeout: auto-increment on, waitrequest stuck high
    setInputs(0, 0, 0, 0, 1, 16'h0001, 0, 16'h0000);
    tick();
    checkOutput("to_autoinc_status", 32'(status), 32'h0004);
    setInputs(0, 0, 0, 1, 0, 16'h0000, 1, 16'hCAFE);
    tick();
    checkOutput("to_read_start", 32'(av_read), 32'd1);
    setInputs(0, 0, 0, 0, 0, 16'h0000, 1, 16'hCAFE);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput($sformatf("to_read_hold%0d", i), 32'(av_read), 32'd1);
    end
    tick();
    checkOutput("to_read_dropped", 32'(av_read), 32'd0);
    checkOutput("to_wait_done", 32'(mcu_wait), 32'd1);
    checkOutput("to_status_done", 32'(status), 32'h0007);
    checkOutput("to_read_data_kept", 32'(read_data), 32'h5555);
    tick();
    checkOutput("to_wait_idle", 32'(mcu_wait), 32'd0);
    checkOutput("to_status_idle", 32'(status), 32'h0006);
    checkOutput("to_address_kept", av_address, 32'h00010002);
    checkOutput("to_read_data_idle", 32'(read_data), 32'h5555);
    setInputs(0, 0, 0, 0, 1, 16'h0002, 0, 16'h0000);
    tick();
    checkOutput("to_flag_cleared", 32'(status), 32'h0000);

    // Reset mid-transaction while READ is stalled
    setInputs(0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000);
    tick();
    checkOutput("rst_read_active", 32'(av_read), 32'd1);
    setInputs(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000);
    #2;
    sysreset = 1'b1;
    #1;
    checkOutput("rst_av_read", 32'(av_read), 32'd0);
    checkOutput("rst_mcu_wait", 32'(mcu_wait), 32'd0);
    checkOutput("rst_address", av_address, 32'd0);
    checkOutput("rst_write_data", 32'(write_data), 32'd0);
    checkOutput("rst_read_data", 32'(read_data), 32'd0);
    checkOutput("rst_status", 32'(status), 32'd0);
    @(negedge sysclk);
    sysreset = 1'b0;
    tick();
    checkOutput("post_rst_wait", 32'(mcu_wait), 32'd0);
    checkOutput("post_rst_read", 32'(av_read), 32'd0);
    setInputs(0, 0, 1, 0, 0, 16'h1111, 0, 16'h0000);
    tick();
    checkOutput("post_rst_write", 32'(av_write), 32'd1);
    checkOutput("post_rst_wdata", 32'(av_writedata), 32'h1111);
    setInputs(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    tick();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
